// File: rtl/mul_16.sv
// Sequential 16x16 unsigned shift-and-add multiplier with a start/busy/done handshake.
// Each RUN cycle adds the multiplicand into the upper accumulator half and shifts right once.

module adder_16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [15:0] sum
);
  assign sum = x + y;
endmodule

module mul_16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [15:0] m, acc_hi, acc_lo;
  logic [4:0]  cnt;
  logic [15:0] sum;
  logic        c;
  logic [15:0] hi_n, lo_n;

  adder_16 u_add (.x(acc_hi), .y(m), .sum(sum));

  // The adder drops its carry-out; recover it from the operand and sum MSBs.
  assign c = (acc_hi[15] & m[15]) | ((acc_hi[15] ^ m[15]) & ~sum[15]);

  always_comb begin
    if (acc_lo[0]) {hi_n, lo_n} = {c, sum, acc_lo[15:1]};
    else           {hi_n, lo_n} = {1'b0, acc_hi, acc_lo[15:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      m       <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            m      <= a;
            acc_lo <= b;
            acc_hi <= '0;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          acc_hi <= hi_n;
          acc_lo <= lo_n;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd15) begin
            product <= {hi_n, lo_n};
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_mul_16.sv
// Scoreboard bench for mul_16: accepted starts push a*b, a negedge monitor pops on done.
`timescale 1ns/1ps
module tb_mul_16;
  logic        clk, reset, start, busy, done;
  logic [15:0] a, b;
  logic [31:0] product;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_prod = '0;
  int          run_len = 0;
  bit          rst_hit = 1'b1;

  mul_16 dut (.clk(clk), .reset(reset), .start(start), .a(a), .b(b),
              .busy(busy), .done(done), .product(product));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a start is taken whenever the unit is not iterating and reset is low.
  always @(posedge clk) begin
    rst_hit = reset;
    if (reset) exp_q.delete();
    else if (start && !busy) exp_q.push_back({16'd0, a} * {16'd0, b});
  end

  always @(negedge clk) begin
    if (rst_hit) begin
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 32'd0) begin
        bad++;
        $display("FAIL reset_state busy=%b done=%b product=%h want 0 0 00000000", busy, done, product);
      end
      last_prod = '0;
      run_len = 0;
    end else if (done === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL spurious_done product=%h want no done", product);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (product !== e) begin
          bad++;
          $display("FAIL product got=%h want=%h", product, e);
        end
      end
      total++;
      if (run_len != 16) begin
        bad++;
        $display("FAIL busy_len got=%0d want=16", run_len);
      end
      run_len = 0;
      last_prod = product;
    end else begin
      if (busy === 1'b1) run_len++;
      else run_len = 0;
      total++;
      if (product !== last_prod) begin
        bad++;
        $display("FAIL product_hold got=%h want=%h", product, last_prod);
      end
    end
  end

  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) return;
    end
    total++; bad++;
    $display("FAIL done_timeout got=no_done want=done within 40 cycles");
  endtask

  task automatic mul(input logic [15:0] x, input logic [15:0] y, input bit b2b);
    if (!b2b) begin @(posedge clk); #1; end
    issue(x, y);
    wait_done();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    mul(16'd3, 16'd5, 0);
    mul(16'hFFFF, 16'hFFFF, 0);
    mul(16'h0000, 16'h1234, 0);
    mul(16'hABCD, 16'h0001, 0);

    // Start pulsed mid-run must be ignored.
    @(posedge clk); #1;
    issue(16'd7, 16'd9);
    repeat (4) @(posedge clk);
    #1 a = 16'd2; b = 16'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (20) @(posedge clk);
    #1;

    // Reset mid-run discards the operation; a start coincident with reset is dropped.
    issue(16'h1000, 16'h0100);
    repeat (7) @(posedge clk);
    #1 reset = 1'b1; start = 1'b1; a = 16'h5555; b = 16'h3333;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    issue(16'h1000, 16'h0100);
    wait_done();

    // Back-to-back.
    mul(16'd6, 16'd7, 0);
    mul(16'h00FF, 16'h0101, 1);

    for (int i = 0; i < 30; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom);
      y = 16'($urandom);
      if (i % 7 == 0) x = 16'hFFFF;
      mul(x, y, bit'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
